// File: rtl/riscv_wb_arbiter.sv
// Register-file write-port arbiter: merges the non-stallable pipeline writeback with
// MDU results (valid/ready), and keeps a scoreboard of MDU-reserved destinations.
module riscv_wb_arbiter #(
  parameter int unsigned XLEN       = 32,
  parameter int unsigned STARVE_MAX = 4
) (
  input  logic            clk,
  input  logic            reset,
  input  logic            pipe_we,
  input  logic [4:0]      pipe_rd,
  input  logic [XLEN-1:0] pipe_wd,
  input  logic            mdu_valid,
  output logic            mdu_ready,
  input  logic [4:0]      mdu_rd,
  input  logic [XLEN-1:0] mdu_wd,
  input  logic            issue_valid,
  input  logic [4:0]      issue_rd,
  input  logic [4:0]      ra1,
  input  logic [4:0]      ra2,
  output logic            stall_rs,
  output logic            wb_stall,
  output logic [31:0]     pending,
  output logic            we3,
  output logic [4:0]      wa3,
  output logic [XLEN-1:0] wd3
);

  localparam int unsigned NREG  = 32;
  localparam int unsigned RW    = 5;
  localparam int unsigned CNT_W = 4;

  logic            we3_q, we3_d;
  logic [RW-1:0]   wa3_q, wa3_d;
  logic [XLEN-1:0] wd3_q, wd3_d;
  logic [NREG-1:0] pending_q, pending_d;
  logic            hold_valid_q, hold_valid_d;
  logic [RW-1:0]   hold_rd_q, hold_rd_d;
  logic [XLEN-1:0] hold_wd_q, hold_wd_d;
  logic [CNT_W-1:0] starve_q, starve_d;

  logic            pipe_req;
  logic            mdu_xfer;
  logic            mdu_live;
  logic [NREG-1:0] set_vec;
  logic [NREG-1:0] clr_vec;

  assign mdu_ready = !hold_valid_q && !reset;
  assign pipe_req  = pipe_we && (pipe_rd != RW'(0));
  assign mdu_xfer  = mdu_valid && mdu_ready;
  // An accepted beat to x0 completes the handshake but is otherwise dropped.
  assign mdu_live  = mdu_xfer && (mdu_rd != RW'(0));

  // Priority: pipe, then held MDU result, then a fresh MDU beat.
  always_comb begin
    we3_d        = 1'b0;
    wa3_d        = wa3_q;
    wd3_d        = wd3_q;
    hold_valid_d = hold_valid_q;
    hold_rd_d    = hold_rd_q;
    hold_wd_d    = hold_wd_q;
    starve_d     = starve_q;
    set_vec      = '0;
    clr_vec      = '0;

    if (pipe_req) begin
      we3_d = 1'b1;
      wa3_d = pipe_rd;
      wd3_d = pipe_wd;
      if (mdu_live) begin
        hold_valid_d = 1'b1;
        hold_rd_d    = mdu_rd;
        hold_wd_d    = mdu_wd;
      end
      if (hold_valid_q && (starve_q != CNT_W'(STARVE_MAX))) begin
        starve_d = starve_q + CNT_W'(1);
      end
    end else if (hold_valid_q) begin
      we3_d              = 1'b1;
      wa3_d              = hold_rd_q;
      wd3_d              = hold_wd_q;
      hold_valid_d       = 1'b0;
      starve_d           = '0;
      clr_vec[hold_rd_q] = 1'b1;
    end else if (mdu_live) begin
      we3_d           = 1'b1;
      wa3_d           = mdu_rd;
      wd3_d           = mdu_wd;
      clr_vec[mdu_rd] = 1'b1;
    end

    if (issue_valid && (issue_rd != RW'(0))) begin
      set_vec[issue_rd] = 1'b1;
    end

    // Set applied after clear so a same-cycle reservation survives.
    pending_d    = (pending_q & ~clr_vec) | set_vec;
    pending_d[0] = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      we3_q        <= 1'b0;
      wa3_q        <= '0;
      wd3_q        <= '0;
      pending_q    <= '0;
      hold_valid_q <= 1'b0;
      hold_rd_q    <= '0;
      hold_wd_q    <= '0;
      starve_q     <= '0;
    end else begin
      we3_q        <= we3_d;
      wa3_q        <= wa3_d;
      wd3_q        <= wd3_d;
      pending_q    <= pending_d;
      hold_valid_q <= hold_valid_d;
      hold_rd_q    <= hold_rd_d;
      hold_wd_q    <= hold_wd_d;
      starve_q     <= starve_d;
    end
  end

  assign we3      = we3_q;
  assign wa3      = wa3_q;
  assign wd3      = wd3_q;
  assign pending  = pending_q;
  assign wb_stall = (starve_q == CNT_W'(STARVE_MAX));
  assign stall_rs = ((ra1 != RW'(0)) && pending_q[ra1]) ||
                    ((ra2 != RW'(0)) && pending_q[ra2]);

endmodule
